// File: rtl/l2_cache_pkg.sv
// Shared definitions for the L2 trace command decoder: command codes, cache-core
// operation kinds, decoder states, default geometry and a saturating counter helper.
package l2_cache_pkg;

   localparam int unsigned DEF_CMD_SIZE   = 8;
   localparam int unsigned DEF_ADDR_SIZE  = 32;
   localparam int unsigned DEF_WAYS       = 8;
   localparam int unsigned DEF_INDEX_BITS = 14;
   localparam int unsigned DEF_TAG_BITS   = 10;

   localparam logic [7:0] CMD_DRD      = 8'd0;
   localparam logic [7:0] CMD_DWR      = 8'd1;
   localparam logic [7:0] CMD_IRD      = 8'd2;
   localparam logic [7:0] CMD_SNP_INV  = 8'd3;
   localparam logic [7:0] CMD_SNP_RD   = 8'd4;
   localparam logic [7:0] CMD_SNP_WR   = 8'd5;
   localparam logic [7:0] CMD_SNP_RWIM = 8'd6;
   localparam logic [7:0] CMD_CLEAR    = 8'd8;
   localparam logic [7:0] CMD_PRINT    = 8'd9;

   // Codes 0-6 map one-to-one onto the first seven kinds.
   typedef enum logic [3:0] {
      RD_DATA    = 4'd0,
      WR_DATA    = 4'd1,
      RD_INSTR   = 4'd2,
      SNP_INV    = 4'd3,
      SNP_RD     = 4'd4,
      SNP_WR     = 4'd5,
      SNP_RWIM   = 4'd6,
      CLEAR_SET  = 4'd7,
      PRINT_LINE = 4'd8
   } op_kind_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_CLEAR = 2'd2,
      ST_PRINT = 2'd3
   } state_e;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/l2_sweep_counter.sv
// Nested index/way counter that walks the cache during maintenance sweeps; the way
// loop is only used when i_inner_en is high (print), otherwise one step per set.
module l2_sweep_counter
   import l2_cache_pkg::*;
#(
   parameter int indexBits = DEF_INDEX_BITS,
   parameter int ways      = DEF_WAYS
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_clear,
   input  logic                     i_advance,
   input  logic                     i_inner_en,
   output logic [indexBits-1:0]     o_index,
   output logic [$clog2(ways)-1:0]  o_way,
   output logic                     o_last
);

   localparam int WAY_W = $clog2(ways);
   localparam logic [WAY_W-1:0] WAY_MAX = WAY_W'(ways - 1);

   logic [indexBits-1:0] r_index;
   logic [WAY_W-1:0]     r_way;

   // Way is the inner loop; the index steps when the way wraps or is unused.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_index <= '0;
         r_way   <= '0;
      end else if (i_advance) begin
         if (i_inner_en && (r_way != WAY_MAX)) begin
            r_way <= r_way + WAY_W'(1'b1);
         end else begin
            r_way   <= '0;
            r_index <= r_index + indexBits'(1'b1);
         end
      end
   end

   assign o_index = r_index;
   assign o_way   = r_way;
   assign o_last  = (r_index == {indexBits{1'b1}}) && (!i_inner_en || (r_way == WAY_MAX));

endmodule

// File: rtl/l2_trace_cmd_decoder.sv
// Turns the trace command/address stream into cache-core operations, expanding
// clear/print into full-cache sweeps and keeping saturating request statistics.
module l2_trace_cmd_decoder
   import l2_cache_pkg::*;
#(
   parameter int commandSize     = DEF_CMD_SIZE,
   parameter int instructionSize = DEF_ADDR_SIZE,
   parameter int ways            = DEF_WAYS,
   parameter int indexBits       = DEF_INDEX_BITS,
   parameter int tagBits         = DEF_TAG_BITS
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_cmd_valid,
   output logic                       o_cmd_ready,
   input  logic [commandSize-1:0]     i_command,
   input  logic [instructionSize-1:0] i_address,
   output logic                       o_op_valid,
   input  logic                       i_op_ready,
   output logic [3:0]                 o_op_kind,
   output logic                       o_op_snoop,
   output logic [tagBits-1:0]         o_op_tag,
   output logic [indexBits-1:0]       o_op_index,
   output logic [$clog2(ways)-1:0]    o_op_way,
   output logic                       o_bad_cmd,
   output logic [31:0]                o_n_reads,
   output logic [31:0]                o_n_writes,
   output logic [31:0]                o_n_snoops
);

   localparam int OFFSET = instructionSize - indexBits - tagBits;
   localparam int WAY_W  = $clog2(ways);

   state_e               r_state;
   state_e               w_next_state;
   op_kind_e             r_kind;
   op_kind_e             w_op_kind;
   logic [tagBits-1:0]   r_tag;
   logic [indexBits-1:0] r_index;
   logic                 r_bad;
   logic [31:0]          r_n_reads;
   logic [31:0]          r_n_writes;
   logic [31:0]          r_n_snoops;
   logic                 w_cmd_hs;
   logic                 w_op_hs;
   logic                 w_is_access;
   logic                 w_sweep_start;
   logic                 w_sweep_adv;
   logic                 w_sweep_last;
   logic [indexBits-1:0] w_sw_index;
   logic [WAY_W-1:0]     w_sw_way;
   logic                 w_unused_offset;

   assign o_cmd_ready     = (r_state == ST_IDLE);
   assign w_cmd_hs        = i_cmd_valid && o_cmd_ready;
   assign w_op_hs         = o_op_valid && i_op_ready;
   assign w_is_access     = (i_command <= CMD_SNP_RWIM);
   assign w_sweep_start   = w_cmd_hs && ((i_command == CMD_CLEAR) || (i_command == CMD_PRINT));
   assign w_sweep_adv     = w_op_hs && ((r_state == ST_CLEAR) || (r_state == ST_PRINT));
   assign w_unused_offset = ^i_address[OFFSET-1:0];

   l2_sweep_counter #(
      .indexBits (indexBits),
      .ways      (ways)
   ) u_sweep (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_clear    (w_sweep_start),
      .i_advance  (w_sweep_adv),
      .i_inner_en (r_state == ST_PRINT),
      .o_index    (w_sw_index),
      .o_way      (w_sw_way),
      .o_last     (w_sweep_last)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_cmd_hs && w_is_access) begin
               w_next_state = ST_ISSUE;
            end else if (w_cmd_hs && (i_command == CMD_CLEAR)) begin
               w_next_state = ST_CLEAR;
            end else if (w_cmd_hs && (i_command == CMD_PRINT)) begin
               w_next_state = ST_PRINT;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (i_op_ready) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_ISSUE;
            end
         end
         ST_CLEAR, ST_PRINT: begin
            if (w_op_hs && w_sweep_last) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = r_state;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Output decode; every term comes from a register so outputs hold while stalled.
   always_comb begin
      o_op_valid = 1'b0;
      w_op_kind  = r_kind;
      o_op_tag   = r_tag;
      o_op_index = r_index;
      o_op_way   = '0;
      case (r_state)
         ST_ISSUE: o_op_valid = 1'b1;
         ST_CLEAR: begin
            o_op_valid = 1'b1;
            w_op_kind  = CLEAR_SET;
            o_op_tag   = '0;
            o_op_index = w_sw_index;
         end
         ST_PRINT: begin
            o_op_valid = 1'b1;
            w_op_kind  = PRINT_LINE;
            o_op_tag   = '0;
            o_op_index = w_sw_index;
            o_op_way   = w_sw_way;
         end
         default: o_op_valid = 1'b0;
      endcase
   end

   assign o_op_kind  = w_op_kind;
   assign o_op_snoop = (w_op_kind == SNP_INV) || (w_op_kind == SNP_RD) ||
                       (w_op_kind == SNP_WR)  || (w_op_kind == SNP_RWIM);

   // Command capture, illegal-code pulse and statistics.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_kind     <= RD_DATA;
         r_tag      <= '0;
         r_index    <= '0;
         r_bad      <= 1'b0;
         r_n_reads  <= 32'd0;
         r_n_writes <= 32'd0;
         r_n_snoops <= 32'd0;
      end else begin
         r_bad <= 1'b0;
         if (w_cmd_hs) begin
            if (w_is_access) begin
               r_kind  <= op_kind_e'(i_command[3:0]);
               r_tag   <= i_address[instructionSize-1 -: tagBits];
               r_index <= i_address[OFFSET +: indexBits];
            end
            case (i_command)
               CMD_DRD, CMD_IRD: r_n_reads  <= sat_inc(r_n_reads);
               CMD_DWR:          r_n_writes <= sat_inc(r_n_writes);
               CMD_SNP_INV, CMD_SNP_RD, CMD_SNP_WR, CMD_SNP_RWIM:
                                 r_n_snoops <= sat_inc(r_n_snoops);
               CMD_CLEAR: begin
                  r_n_reads  <= 32'd0;
                  r_n_writes <= 32'd0;
                  r_n_snoops <= 32'd0;
               end
               CMD_PRINT:        r_bad      <= 1'b0;
               default:          r_bad      <= 1'b1;
            endcase
         end
      end
   end

   assign o_bad_cmd  = r_bad;
   assign o_n_reads  = r_n_reads;
   assign o_n_writes = r_n_writes;
   assign o_n_snoops = r_n_snoops;

endmodule

// File: tb/tb_l2_trace_cmd_decoder.sv
// Randomised bench for l2_trace_cmd_decoder with a queue-based reference model of
// the expected operation stream and statistics, built with a small sweep geometry.
module tb_l2_trace_cmd_decoder;

   localparam int IB = 3;
   localparam int WY = 2;
   localparam int TB = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  command;
   logic [31:0] address;
   logic        op_valid;
   logic        op_ready;
   logic [3:0]  op_kind;
   logic        op_snoop;
   logic [TB-1:0] op_tag;
   logic [IB-1:0] op_index;
   logic [0:0]  op_way;
   logic        bad_cmd;
   logic [31:0] n_reads, n_writes, n_snoops;

   l2_trace_cmd_decoder #(.indexBits(IB), .ways(WY), .tagBits(TB)) dut (
      .i_clk(clk), .i_reset(reset), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_command(command), .i_address(address), .o_op_valid(op_valid), .i_op_ready(op_ready),
      .o_op_kind(op_kind), .o_op_snoop(op_snoop), .o_op_tag(op_tag), .o_op_index(op_index),
      .o_op_way(op_way), .o_bad_cmd(bad_cmd), .o_n_reads(n_reads), .o_n_writes(n_writes),
      .o_n_snoops(n_snoops)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;
      int tag;
      int idx;
      int way;
      bit snp;
   } op_t;

   op_t         q[$];
   int unsigned m_reads, m_writes, m_snoops;
   bit          m_bad, m_acc, m_init;
   int          n_vec = 0;
   int          n_err = 0;
   int          n_print_hs;
   bit          rnd_ready;

   function automatic int unsigned sat(input int unsigned v);
      return (v == 32'hFFFF_FFFF) ? v : v + 1;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference behaviour: a command becomes a list of pending ops; the decoder
   // only takes a new command when that list is empty.
   task automatic decode(input int c, input logic [31:0] a);
      op_t o;
      if (c <= 6) begin
         o.kind = c;
         o.tag  = int'(a >> (32 - TB));
         o.idx  = int'((a >> (32 - TB - IB)) % (1 << IB));
         o.way  = 0;
         o.snp  = (c >= 3);
         q.push_back(o);
         if (c == 1)      m_writes = sat(m_writes);
         else if (c >= 3) m_snoops = sat(m_snoops);
         else             m_reads  = sat(m_reads);
      end else if (c == 8) begin
         for (int i = 0; i < (1 << IB); i++) begin
            o.kind = 7; o.tag = 0; o.idx = i; o.way = 0; o.snp = 1'b0;
            q.push_back(o);
         end
         m_reads = 0; m_writes = 0; m_snoops = 0;
      end else if (c == 9) begin
         for (int i = 0; i < (1 << IB); i++) begin
            for (int w = 0; w < WY; w++) begin
               o.kind = 8; o.tag = 0; o.idx = i; o.way = w; o.snp = 1'b0;
               q.push_back(o);
            end
         end
      end else begin
         m_bad = 1'b1;
      end
   endtask

   always @(posedge clk) begin
      m_acc = 1'b0;
      if (reset) begin
         q.delete();
         m_reads = 0; m_writes = 0; m_snoops = 0;
         m_bad  = 1'b0;
         m_init = 1'b1;
      end else if (m_init) begin
         m_bad = 1'b0;
         if (q.size() != 0) begin
            if (op_ready) begin
               if (q[0].kind == 8) n_print_hs++;
               void'(q.pop_front());
            end
         end else if (cmd_valid) begin
            m_acc = 1'b1;
            decode(int'(command), address);
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("cmd_ready", cmd_ready, q.size() == 0);
         chk("op_valid", op_valid, q.size() != 0);
         if (q.size() != 0) begin
            chk("op_kind", op_kind, q[0].kind);
            chk("op_tag", op_tag, q[0].tag);
            chk("op_index", op_index, q[0].idx);
            chk("op_way", op_way, q[0].way);
            chk("op_snoop", op_snoop, q[0].snp);
         end
         chk("bad_cmd", bad_cmd, m_bad);
         chk("n_reads", n_reads, m_reads);
         chk("n_writes", n_writes, m_writes);
         chk("n_snoops", n_snoops, m_snoops);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_ready) op_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [7:0] c, input logic [31:0] a);
      bit got;
      got       = 1'b0;
      cmd_valid = 1'b1;
      command   = c;
      address   = a;
      for (int k = 0; k < 400 && !got; k++) begin
         tick();
         got = m_acc;
      end
      cmd_valid = 1'b0;
      if (!got) begin
         n_vec++; n_err++;
         $display("FAIL send_timeout: command %0d not accepted, required acceptance", c);
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (q.size() != 0 && k < 400) begin
         tick();
         k++;
      end
      chk("drain_empty", q.size(), 0);
   endtask

   initial begin
      bit found;
      int c;
      int r;
      reset = 1'b1; cmd_valid = 1'b0; command = 8'd0; address = 32'd0;
      op_ready = 1'b1; rnd_ready = 1'b0; n_print_hs = 0;
      tick(); tick();
      chk("rst_op_valid", op_valid, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_kind", op_kind, 0);
      chk("rst_tag", op_tag, 0);
      chk("rst_index", op_index, 0);
      chk("rst_way", op_way, 0);
      chk("rst_bad", bad_cmd, 0);
      chk("rst_cnt", {n_reads, n_writes | n_snoops}, 0);
      reset = 1'b0;

      send(8'd0, 32'hABCD_1234);
      chk("pin_valid", op_valid, 1);
      chk("pin_kind", op_kind, 0);
      chk("pin_tag", op_tag, 10'h2AF);
      chk("pin_index", op_index, 1);
      chk("pin_reads", n_reads, 1);
      chk("pin_ready", cmd_ready, 0);
      drain();

      op_ready = 1'b0;
      send(8'd1, $urandom);
      repeat (5) tick();
      chk("stall_valid", op_valid, 1);
      chk("stall_ready", cmd_ready, 0);
      chk("stall_writes", n_writes, 1);
      op_ready = 1'b1;
      tick();
      chk("release_valid", op_valid, 0);
      tick();
      chk("single_op", op_valid, 0);

      send(8'd7, $urandom);
      chk("bad7_pulse", bad_cmd, 1);
      chk("bad7_noop", op_valid, 0);
      tick();
      chk("bad7_end", bad_cmd, 0);
      send(8'd12, $urandom);
      chk("bad12_pulse", bad_cmd, 1);
      tick();
      chk("bad12_end", bad_cmd, 0);
      chk("bad_reads", n_reads, 1);

      send(8'd8, 32'd0);
      chk("clear_reads", n_reads, 0);
      chk("clear_writes", n_writes, 0);
      drain();
      chk("clear_idle", cmd_ready, 1);

      rnd_ready = 1'b1;
      n_print_hs = 0;
      send(8'd9, 32'd0);
      drain();
      chk("print_count", n_print_hs, 16);

      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 19);
         if (r < 14)       c = r % 7;
         else if (r == 14) c = 8;
         else if (r == 15) c = 9;
         else if (r == 16) c = 7;
         else              c = $urandom_range(10, 255);
         send(c[7:0], $urandom);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 3)) tick();
      end
      drain();
      rnd_ready = 1'b0;
      op_ready  = 1'b1;

      send(8'd0, $urandom);
      send(8'd9, 32'd0);
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         if (q.size() != 0 && q[0].idx == 3) found = 1'b1;
         else tick();
      end
      chk("print_reach_idx3", found, 1);
      reset = 1'b1;
      tick();
      chk("midrst_valid", op_valid, 0);
      chk("midrst_ready", cmd_ready, 1);
      chk("midrst_reads", n_reads, 0);
      reset = 1'b0;
      tick();
      chk("midrst_idle", op_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
